// File: rtl/fmadd_bf16_normalizer.sv
`timescale 1ns/1ps
// fmadd_bf16_normalizer
// Normalizes the unnormalized FMADD adder result, rounds it to nearest-even and
// packs a bfloat16 with exception flags. Three-stage valid/ready pipeline:
//   S1: register input beat, count leading zeros of the mantissa
//   S2: left-normalize mantissa, adjust exponent (e = exp - k)
//   S3: round, handle zero/underflow/overflow, drive registered outputs
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake
//   in_sign/in_exp/in_mant    sign, signed biased exponent, unnormalized magnitude
//   out_valid/out_ready       downstream handshake
//   out_data                  bf16 {sign, exp[7:0], frac[6:0]}
//   out_flags                 {overflow, underflow, inexact}
module fmadd_bf16_normalizer #(
    parameter int unsigned MAN_W   = 24,
    parameter int unsigned EXP_W   = 10,
    parameter int unsigned OUT_MAN = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [2:0]       out_flags
);

    localparam int unsigned K_W = $clog2(MAN_W + 1);
    localparam int unsigned E_W = EXP_W + 1;
    // Fraction below the hidden bit after normalization
    localparam int unsigned F_W = MAN_W - 1;
    // Guard bit position within the fraction
    localparam int unsigned GRD = F_W - OUT_MAN - 1;

    // Stage registers
    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                    s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]        s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0]        s1_mant_q, s1_mant_d;
    logic                    s2_sign_q, s2_sign_d;
    logic                    s2_zero_q, s2_zero_d;
    logic signed [E_W-1:0]   s2_exp_q, s2_exp_d;
    logic [F_W-1:0]          s2_frac_q, s2_frac_d;
    logic [15:0]             s3_data_q, s3_data_d;
    logic [2:0]              s3_flags_q, s3_flags_d;

    // Combinational helpers
    logic                    ld1_c, ld2_c, ld3_c;
    logic [K_W-1:0]          k_c;
    logic signed [E_W-1:0]   e_c;
    logic [OUT_MAN-1:0]      kf_c;
    logic                    guard_c, sticky_c, rnd_up_c;
    logic [OUT_MAN:0]        frac_rnd_c;
    logic signed [E_W:0]     e_fin_c;
    logic [15:0]             res_data_c;
    logic [2:0]              res_flags_c;

    // A stage can load when it is empty or its content moves on this cycle
    assign ld3_c    = ~v3_q | out_ready;
    assign ld2_c    = ~v2_q | ld3_c;
    assign ld1_c    = ~v1_q | ld2_c;
    assign in_ready = ld1_c;

    // Leading-zero count; highest set bit wins, k = MAN_W for a zero mantissa
    always_comb begin
        k_c = K_W'(MAN_W);
        for (int i = 0; i < int'(MAN_W); i++) begin
            if (s1_mant_q[i]) begin
                k_c = K_W'(int'(MAN_W) - 1 - i);
            end
        end
    end

    // Exponent adjust at one extra bit so exp - k never wraps
    assign e_c = E_W'($signed(s1_exp_q)) - E_W'(k_c);

    // Round to nearest-even, then apply special cases in priority order
    always_comb begin
        kf_c       = s2_frac_q[F_W-1 -: OUT_MAN];
        guard_c    = s2_frac_q[GRD];
        sticky_c   = |s2_frac_q[GRD-1:0];
        rnd_up_c   = guard_c & (sticky_c | kf_c[0]);
        // Carry out of the stored fraction means the mantissa rolled to 2.0
        frac_rnd_c = {1'b0, kf_c} + (OUT_MAN + 1)'(rnd_up_c);
        e_fin_c    = (E_W + 1)'(s2_exp_q) + (E_W + 1)'(frac_rnd_c[OUT_MAN]);

        res_data_c  = {s2_sign_q, e_fin_c[7:0], frac_rnd_c[OUT_MAN-1:0]};
        res_flags_c = {2'b00, guard_c | sticky_c};
        if (s2_zero_q) begin
            res_data_c  = {s2_sign_q, 15'h0000};
            res_flags_c = 3'b000;
        end else if (s2_exp_q <= E_W'(0)) begin
            res_data_c  = {s2_sign_q, 15'h0000};
            res_flags_c = 3'b011;
        end else if (e_fin_c >= (E_W + 1)'(255)) begin
            res_data_c  = {s2_sign_q, 8'hFF, 7'h00};
            res_flags_c = 3'b101;
        end
    end

    // Next-state for all stages; data only loads when a valid beat enters
    always_comb begin
        v1_d       = v1_q;
        v2_d       = v2_q;
        v3_d       = v3_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_exp_d   = s2_exp_q;
        s2_frac_d  = s2_frac_q;
        s3_data_d  = s3_data_q;
        s3_flags_d = s3_flags_q;

        if (ld1_c) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_exp_d  = in_exp;
                s1_mant_d = in_mant;
            end
        end

        if (ld2_c) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_sign_d = s1_sign_q;
                s2_zero_d = ~|s1_mant_q;
                s2_exp_d  = e_c;
                // Shifting only the fraction bits drops the hidden bit for free
                s2_frac_d = s1_mant_q[F_W-1:0] << k_c;
            end
        end

        // Outputs hold while stalled because ld3_c is low
        if (ld3_c) begin
            v3_d = v2_q;
            if (v2_q) begin
                s3_data_d  = res_data_c;
                s3_flags_d = res_flags_c;
            end
        end
    end

    // State registers; reset discards every in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            s3_data_q  <= 16'h0000;
            s3_flags_q <= 3'b000;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_exp_q   <= s2_exp_d;
            s2_frac_q  <= s2_frac_d;
            s3_data_q  <= s3_data_d;
            s3_flags_q <= s3_flags_d;
        end
    end

    assign out_valid = v3_q;
    assign out_data  = s3_data_q;
    assign out_flags = s3_flags_q;

endmodule

// File: tb/tb_fmadd_bf16_normalizer.sv
`timescale 1ns/1ps
// Testbench for fmadd_bf16_normalizer: scoreboard of expected {data, flags},
// filled by the driver on each accepted beat and drained by an output monitor.
module tb_fmadd_bf16_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [23:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;

    always #5 clk = ~clk;

    fmadd_bf16_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [18:0] sb[$];
    int          stamp[$];
    int          pop_cyc[$];
    bit          lat_mode = 1'b0;
    bit          rdy_rand = 1'b0;
    logic        rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: forced level or random backpressure
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
    endtask

    // Reference: value = mant/2^23 * 2^(exp-127); normalize arithmetically,
    // round by comparing the discarded remainder against one half.
    function automatic logic [18:0] model(input logic s, input int e_in, input int unsigned m);
        int unsigned n, keep, rem;
        int e;
        if (m == 0) return {s, 15'h0000, 3'b000};
        n = m;
        e = e_in;
        while (n < 32'h0080_0000) begin
            n = n * 2;
            e = e - 1;
        end
        if (e <= 0) return {s, 15'h0000, 3'b011};
        keep = n / 65536;
        rem  = n % 65536;
        if (rem > 32768 || (rem == 32768 && (keep % 2) == 1)) keep = keep + 1;
        if (keep == 256) begin
            keep = 128;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00, 3'b101};
        return {s, 8'(e), 7'(keep - 128), 2'b00, rem != 0};
    endfunction

    // Output monitor: pop and compare every transfer
    always @(negedge clk) begin
        logic [18:0] e;
        int st;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("output_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                st = stamp.pop_front();
                chk("out_data", 32'(out_data), 32'(e[18:3]));
                chk("out_flags", 32'(out_flags), 32'(e[2:0]));
                if (lat_mode) chk("latency", 32'(cyc - st), 32'd3);
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input logic s, input logic [9:0] e, input logic [23:0] m,
                        input logic [18:0] exp_v, input bit use_model);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(use_model ? model(s, int'($signed(e)), 32'(m)) : exp_v);
                stamp.push_back(cyc);
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && sb.size() != 0; n++) @(posedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] hold_d;
        logic [2:0]  hold_f;
        logic        s;
        logic [9:0]  e;
        logic [23:0] m;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, downstream always ready, latency checked
        lat_mode = 1'b1;
        send(1'b0, 10'd127, 24'h800000, {16'h3F80, 3'b000}, 1'b0);
        send(1'b0, 10'd150, 24'h000001, {16'h3F80, 3'b000}, 1'b0);
        send(1'b1, 10'd127, 24'h000000, {16'h8000, 3'b000}, 1'b0);
        send(1'b0, 10'd127, 24'hC18000, {16'h3FC2, 3'b001}, 1'b0);
        send(1'b0, 10'd127, 24'hC08000, {16'h3FC0, 3'b001}, 1'b0);
        send(1'b0, 10'd127, 24'hC08001, {16'h3FC1, 3'b001}, 1'b0);
        send(1'b0, 10'd254, 24'hFF8000, {16'h7F80, 3'b101}, 1'b0);
        send(1'b0, 10'd10,  24'h000100, {16'h0000, 3'b011}, 1'b0);
        drain();
        lat_mode = 1'b0;

        // Backpressure: three beats fill the pipe, the fourth is refused
        rdy_force = 1'b0;
        send(1'b0, 10'd127, 24'hC18000, 19'h0, 1'b1);
        send(1'b1, 10'd130, 24'h00ABCD, 19'h0, 1'b1);
        send(1'b0, 10'd200, 24'h7FFFFF, 19'h0, 1'b1);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 10'd100;
        in_mant  = 24'h123456;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            if (i == 0) begin
                hold_d = out_data;
                hold_f = out_flags;
            end else begin
                chk("bp_data_stable", 32'(out_data), 32'(hold_d));
                chk("bp_flags_stable", 32'(out_flags), 32'(hold_f));
            end
            @(posedge clk);
            #1;
        end
        pop_cyc.delete();
        rdy_force = 1'b1;
        send(1'b0, 10'd100, 24'h123456, 19'h0, 1'b1);
        send(1'b1, 10'd127, 24'hC08000, 19'h0, 1'b1);
        drain();
        chk("bp_emerged", 32'(pop_cyc.size()), 32'd5);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("bp_no_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

        // Randomized beats with random backpressure and input gaps
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            s = 1'($urandom);
            e = 10'($urandom_range(0, 420)) - 10'd100;
            m = 24'($urandom) >> $urandom_range(0, 24);
            if ($urandom_range(0, 7) == 0) m = {m[23:16], 16'h8000};
            send(s, e, m, 19'h0, 1'b1);
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Reset with three beats in flight
        rdy_force = 1'b0;
        send(1'b0, 10'd127, 24'hC18000, 19'h0, 1'b1);
        send(1'b1, 10'd140, 24'h0F0F0F, 19'h0, 1'b1);
        send(1'b0, 10'd127, 24'hC08001, 19'h0, 1'b1);
        rst = 1'b1;
        sb.delete();
        stamp.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_flags", 32'(out_flags), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rdy_force = 1'b1;
        lat_mode  = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 10'd127, 24'h800000, {16'h3F80, 3'b000}, 1'b0);
        drain();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post_reset_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
